sr_shift_ctrl: RTL and testbench

SR_SHIFT_CTRL -- requirements
Module: sr_shift_ctrl

---
 rtl/sr_ctrl_pkg.sv | 20 ++
 rtl/sr_bit_counter.sv | 50 +++++
 rtl/sr_shift_ctrl.sv | 147 ++++++++++++++
 tb/tb_sr_shift_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types for the shift-register fill/drain test controller.
// Holds the FSM state enum, phase encoding and default chain length.
package sr_ctrl_pkg;

  localparam int SR_LEN_DEF = 128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Phase A drives data with the strobe low, phase B raises the strobe.
  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_t;

endpackage

// File: rtl/sr_bit_counter.sv
// Bit index / phase counter for the fill and drain passes.
// Ports: clr, en in; bit_idx, phase, last plus their next values out.
module sr_bit_counter
  import sr_ctrl_pkg::*;
#(
  parameter  int SR_LEN = SR_LEN_DEF,
  localparam int IW     = $clog2(SR_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] bit_idx,
  output phase_t        phase,
  output logic          last,
  output logic [IW-1:0] idx_nxt,
  output phase_t        phase_nxt
);

  assign last = (bit_idx == IW'(SR_LEN - 1));

  // The next values are exported so the owner can register its
  // strobe and data outputs in step with the counter.
  always_comb begin
    idx_nxt   = bit_idx;
    phase_nxt = phase;
    if (clr) begin
      idx_nxt   = '0;
      phase_nxt = PH_A;
    end else if (en) begin
      if (phase == PH_B) begin
        phase_nxt = PH_A;
        idx_nxt   = last ? '0 : bit_idx + IW'(1);
      end else begin
        phase_nxt = PH_B;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      phase   <= PH_A;
    end else begin
      bit_idx <= idx_nxt;
      phase   <= phase_nxt;
    end
  end

endmodule

// File: rtl/sr_shift_ctrl.sv
// Fill/drain test controller for an external latch shift register.
// Ports: start/abort/pattern in; sr_in/sr_clk/sr_out link; busy/done/pass/err_cnt.
module sr_shift_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter  int SR_LEN = SR_LEN_DEF,
  parameter  int ERR_W  = 9,
  localparam int IW     = $clog2(SR_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       pattern,
  output logic             sr_in,
  output logic             sr_clk,
  input  logic             sr_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       pat_q;
  logic [7:0]       pat_d;
  logic [ERR_W-1:0] err_work_q;
  logic             cap;
  logic             cnt_clr;
  logic             cnt_en;
  logic             xfer_end;
  logic             sample;
  logic             sr_in_d;
  logic             sr_clk_d;

  logic [IW-1:0]    bit_idx;
  logic [IW-1:0]    idx_nxt;
  phase_t           phase;
  phase_t           phase_nxt;
  logic             last;
  logic             unused_idx;

  sr_bit_counter #(
    .SR_LEN (SR_LEN)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .bit_idx   (bit_idx),
    .phase     (phase),
    .last      (last),
    .idx_nxt   (idx_nxt),
    .phase_nxt (phase_nxt)
  );

  // Only the low three index bits select a pattern bit.
  assign unused_idx = ^{bit_idx, idx_nxt};

  assign xfer_end = (phase == PH_B) && last;

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    sample  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!abort && start) begin
          state_d = S_FILL;
          cap     = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      S_FILL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_en = 1'b1;
          if (xfer_end) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_en = 1'b1;
          sample = (phase == PH_A);
          if (xfer_end) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobe and data are registered from next-state values so the
  // shift-register clock comes straight off a flop.
  assign pat_d    = cap ? pattern : pat_q;
  assign sr_clk_d = ((state_d == S_FILL) || (state_d == S_DRAIN))
                    && (phase_nxt == PH_B);
  assign sr_in_d  = (state_d == S_FILL) && pat_d[idx_nxt[2:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      sr_in   <= 1'b0;
      sr_clk  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sr_in   <= sr_in_d;
      sr_clk  <= sr_clk_d;
    end
  end

  // Running count for the test in progress; the visible result only
  // changes on completion, so an abort leaves the last result intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_work_q <= '0;
    end else if (cap) begin
      err_work_q <= '0;
    end else if (sample && (sr_out != pat_q[bit_idx[2:0]])
                 && (err_work_q != '1)) begin
      err_work_q <= err_work_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
      pass    <= 1'b0;
    end else if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
      err_cnt <= err_work_q;
      pass    <= (err_work_q == '0);
    end
  end

  assign busy = (state_q == S_FILL) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_sr_shift_ctrl.sv
// Randomized bench for sr_shift_ctrl with a shift-register model.
// Models ideal, output-stuck-0 and stage-stuck-1 chains.
module tb_sr_shift_ctrl;

  localparam int N  = 128;
  localparam int EW = 9;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [7:0]    pattern;
  logic          sr_in;
  logic          sr_clk;
  logic          sr_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [EW-1:0] err_cnt;

  int errs;
  int checks;
  int mode;
  int stuck_stage;
  int exp_err;
  int exp_pass;
  bit sreg [N];

  sr_shift_ctrl #(
    .SR_LEN (N),
    .ERR_W  (EW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .sr_in   (sr_in),
    .sr_clk  (sr_clk),
    .sr_out  (sr_out),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge sr_clk) begin
    for (int k = N - 1; k > 0; k--) sreg[k] <= sreg[k-1];
    sreg[0] <= sr_in;
    if (mode == 2) sreg[stuck_stage] <= 1'b1;
  end

  assign sr_out = (mode == 1) ? 1'b0 : sreg[N-1];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Mismatches are counted over drained bits: output stuck at 0 misses
  // every 1 bit, a stage stuck at 1 corrupts every 0 bit.
  function automatic int exp_errs(input logic [7:0] p, input int m);
    int e = 0;
    int lim = (1 << EW) - 1;
    for (int j = 0; j < N; j++) begin
      if (m == 1 && p[j % 8] == 1'b1) e++;
      if (m == 2 && p[j % 8] == 1'b0) e++;
    end
    return (e > lim) ? lim : e;
  endfunction

  function automatic logic exp_sr_in(input logic [7:0] p, input int c);
    if (c <= 2 * N) return p[((c - 1) / 2) % 8];
    return 1'b0;
  endfunction

  task automatic run_test(input logic [7:0] p, input int m,
                          input int cut_at, input bit cut_rst,
                          input bit hammer);
    int bad = 0;
    int dones = 0;
    int ee;
    bit fin = 0;
    mode = m;
    stuck_stage = $urandom_range(N - 1, 0);
    ee = exp_errs(p, m);
    @(negedge clk);
    start = 1'b1;
    pattern = p;
    @(posedge clk);
    for (int c = 1; c <= 4 * N + 2 && !fin; c++) begin
      @(negedge clk);
      dones += int'(done);
      if (c <= 4 * N && (cut_at == 0 || c <= cut_at)) begin
        if (sr_clk != (c % 2 == 0) || sr_in != exp_sr_in(p, c)
            || !busy || done)
          bad++;
      end
      if (cut_at == 0 && c == 4 * N + 1) begin
        check("done_at_4n1", int'(done), 1);
        check("busy_in_done", int'(busy), 0);
        check("sr_clk_in_done", int'(sr_clk), 0);
        check("err_cnt", int'(err_cnt), ee);
        check("pass", int'(pass), int'(ee == 0));
        exp_err = ee;
        exp_pass = int'(ee == 0);
      end
      if (cut_at == 0 && c == 4 * N + 2) begin
        check("idle_after_done", int'(busy), 0);
        check("done_width", int'(done), 0);
      end
      if (cut_at != 0 && !cut_rst && c == cut_at + 1) begin
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_sr_clk", int'(sr_clk), 0);
        check("abort_sr_in", int'(sr_in), 0);
        check("abort_err_cnt", int'(err_cnt), exp_err);
        check("abort_pass", int'(pass), exp_pass);
        fin = 1;
      end
      if (cut_at != 0 && c == cut_at && !fin) begin
        if (cut_rst) begin
          check("pre_rst_sr_clk", int'(sr_clk), int'(c % 2 == 0));
          rst_n = 1'b0;
          #1;
          check("rst_sr_clk", int'(sr_clk), 0);
          check("rst_busy", int'(busy), 0);
          check("rst_err_cnt", int'(err_cnt), 0);
          check("rst_pass", int'(pass), 0);
          check("rst_sr_in", int'(sr_in), 0);
          exp_err = 0;
          exp_pass = 0;
          @(negedge clk);
          rst_n = 1'b1;
          fin = 1;
        end else begin
          abort = 1'b1;
        end
      end
      start = hammer && (c < 4 * N + 1);
      pattern = 8'($urandom);
    end
    start = 1'b0;
    check("stream", bad, 0);
    if (cut_at != 0) begin
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        dones += int'(done);
        bad += int'(busy);
      end
      check("no_done_pulse", dones, 0);
      check("stays_idle", bad, 0);
    end else begin
      check("done_once", dones, 1);
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    mode = 0;
    stuck_stage = 0;
    exp_err = 0;
    exp_pass = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    pattern = '0;
    for (int k = 0; k < N; k++) sreg[k] = 1'b0;
    #1;
    check("reset_sr_clk", int'(sr_clk), 0);
    check("reset_sr_in", int'(sr_in), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_pass", int'(pass), 0);
    check("reset_err_cnt", int'(err_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_test(8'hA5, 0, 0, 0, 0);
    run_test(8'hFF, 1, 0, 0, 0);
    run_test(8'h00, 2, 0, 0, 0);
    run_test(8'hFF, 2, 0, 0, 0);
    run_test(8'h00, 1, 0, 0, 0);
    run_test(8'h3C, 2, 300, 0, 0);
    run_test(8'h3C, 2, 0, 0, 0);
    run_test(8'h96, 0, 0, 0, 1);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    pattern = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start", int'(busy), 0);

    run_test(8'hC3, 1, 100, 1, 0);
    run_test(8'hC3, 1, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      logic [7:0] p;
      int m;
      int cut;
      p = 8'($urandom);
      m = $urandom_range(2, 0);
      cut = ($urandom_range(3, 0) == 0) ? $urandom_range(4 * N, 1) : 0;
      run_test(p, m, cut, 0, bit'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
